// File: rtl/ds_sync2.sv
// Two-flop synchronizer for one asynchronous line input.
// Both stages reset to 0, which matches the idle DS line level.
module ds_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic stage1_q;
    logic stage2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= async_i;
            stage2_q <= stage1_q;
        end
    end

    assign sync_o = stage2_q;

endmodule

// File: rtl/rx_ds_se.sv
// Single-ended Data-Strobe receiver: recovers one bit per DS symbol transition
// and emits completed dibits with a one-cycle valid strobe.
module rx_ds_se (
    input  logic       rxClk,
    input  logic       rxReset,
    input  logic       d,
    input  logic       s,
    output logic [1:0] dq,
    output logic       dqValid
);

    typedef enum logic {
        PHASE_FIRST  = 1'b0,
        PHASE_SECOND = 1'b1
    } phase_e;

    localparam logic [1:0] IDLE_LINE = 2'b00;

    logic   dSync;
    logic   sSync;
    logic   dPrev_q;
    logic   sPrev_q;
    logic   firstBit_q;
    phase_e phase_q;
    logic [1:0] dq_q;
    logic   dqValid_q;
    logic   bitEvent;

    ds_sync2 u_syncD (
        .clk_i   (rxClk),
        .rst_i   (rxReset),
        .async_i (d),
        .sync_o  (dSync)
    );

    ds_sync2 u_syncS (
        .clk_i   (rxClk),
        .rst_i   (rxReset),
        .async_i (s),
        .sync_o  (sSync)
    );

    // A single-line toggle flips the D^S parity; a double toggle leaves it unchanged and is lost.
    assign bitEvent = (dSync ^ sSync) != (dPrev_q ^ sPrev_q);

    always_ff @(posedge rxClk or posedge rxReset) begin
        if (rxReset) begin
            {dPrev_q, sPrev_q} <= IDLE_LINE;
            firstBit_q         <= 1'b0;
            phase_q            <= PHASE_FIRST;
            dq_q               <= 2'b00;
            dqValid_q          <= 1'b0;
        end else begin
            dPrev_q   <= dSync;
            sPrev_q   <= sSync;
            dqValid_q <= 1'b0;
            if (bitEvent) begin
                case (phase_q)
                    PHASE_FIRST: begin
                        firstBit_q <= dSync;
                        phase_q    <= PHASE_SECOND;
                    end
                    default: begin
                        dq_q      <= {dSync, firstBit_q};
                        dqValid_q <= 1'b1;
                        phase_q   <= PHASE_FIRST;
                    end
                endcase
            end
        end
    end

    assign dq      = dq_q;
    assign dqValid = dqValid_q;

endmodule

// File: tb/tb_rx_ds_se.sv
// Directed self-checking bench for rx_ds_se: reset, decode, continuity,
// latency, simultaneous toggle and mid-dibit reset.
module tb_rx_ds_se;

   logic       rxClk;
   logic       rxReset;
   logic       d;
   logic       s;
   logic [1:0] dq;
   logic       dqValid;

   int compareCount;
   int mismatchCount;
   int widthErrors;
   logic prevValid;
   logic [1:0] pulseQueue[$];

   rx_ds_se dut (
      .rxClk   (rxClk),
      .rxReset (rxReset),
      .d       (d),
      .s       (s),
      .dq      (dq),
      .dqValid (dqValid)
   );

   // 20 ns receive clock, rising edges at 10, 30, 50 ...
   initial rxClk = 1'b0;
   always #10 rxClk = ~rxClk;

   // Records every dibit strobe away from the active edge and flags pulses wider than one cycle
   always @(negedge rxClk) begin
      if (rxReset) begin
         prevValid = 1'b0;
      end else begin
         if (dqValid === 1'b1) begin
            pulseQueue.push_back(dq);
            if (prevValid) widthErrors++;
         end
         prevValid = (dqValid === 1'b1);
      end
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drives one DS line state and holds it for 1.5 clock periods
   task automatic applyStimulus(input logic dVal, input logic sVal);
      d = dVal;
      s = sVal;
      #30;
   endtask

   task automatic sendBasicSequence();
      applyStimulus(0, 1);
      applyStimulus(1, 1);
      applyStimulus(1, 0);
      applyStimulus(1, 1);
      applyStimulus(0, 1);
      applyStimulus(1, 1);
      applyStimulus(0, 1);
      applyStimulus(0, 0);
   endtask

   initial begin
      int pattern[4];
      int observed;
      pattern[0] = 2; pattern[1] = 3; pattern[2] = 2; pattern[3] = 0;
      compareCount  = 0;
      mismatchCount = 0;
      widthErrors   = 0;
      prevValid     = 1'b0;
      d = 1'b0;
      s = 1'b0;

      // Reset for 30 ns, then confirm idle outputs
      rxReset = 1'b1;
      #30;
      rxReset = 1'b0;
      @(negedge rxClk);
      checkOutput("reset_dq", dq, 0);
      checkOutput("reset_valid", dqValid, 0);
      repeat (2) @(negedge rxClk);
      checkOutput("idle_valid", dqValid, 0);
      checkOutput("idle_no_pulse", pulseQueue.size(), 0);

      // Basic decode: bits 0,1,1,1,0,1,0,0
      pulseQueue.delete();
      sendBasicSequence();
      repeat (5) @(negedge rxClk);
      checkOutput("basic_count", pulseQueue.size(), 4);
      for (int i = 0; i < 4; i++) begin
         observed = (i < pulseQueue.size()) ? int'(pulseQueue[i]) : -1;
         checkOutput($sformatf("basic_dq%0d", i), observed, pattern[i]);
      end
      checkOutput("basic_hold_dq", dq, 0);
      checkOutput("basic_hold_valid", dqValid, 0);

      // Continuity: three back-to-back sequences
      pulseQueue.delete();
      repeat (3) sendBasicSequence();
      repeat (5) @(negedge rxClk);
      checkOutput("cont_count", pulseQueue.size(), 12);
      for (int i = 0; i < 12; i++) begin
         observed = (i < pulseQueue.size()) ? int'(pulseQueue[i]) : -1;
         checkOutput($sformatf("cont_dq%0d", i), observed, pattern[i % 4]);
      end
      checkOutput("width_errors", widthErrors, 0);

      // Latency: s toggle gives bit 0, then d toggle set up before edge N gives bit 1
      pulseQueue.delete();
      applyStimulus(0, 1);
      repeat (4) @(negedge rxClk);
      checkOutput("lat_pre_valid", dqValid, 0);
      d = 1'b1;
      @(negedge rxClk);
      checkOutput("lat_n_valid", dqValid, 0);
      @(negedge rxClk);
      checkOutput("lat_n1_valid", dqValid, 0);
      @(negedge rxClk);
      checkOutput("lat_n2_valid", dqValid, 1);
      checkOutput("lat_n2_dq", dq, 2);
      @(negedge rxClk);
      checkOutput("lat_n3_valid", dqValid, 0);
      checkOutput("lat_count", pulseQueue.size(), 1);

      // Simultaneous toggle from (0,1) to (1,0) must be ignored without disturbing phase
      pulseQueue.delete();
      applyStimulus(0, 1);
      repeat (4) @(negedge rxClk);
      checkOutput("simul_half", pulseQueue.size(), 0);
      d = 1'b1;
      s = 1'b0;
      repeat (6) @(negedge rxClk);
      checkOutput("simul_no_pulse", pulseQueue.size(), 0);
      applyStimulus(1, 1);
      repeat (5) @(negedge rxClk);
      checkOutput("simul_count", pulseQueue.size(), 1);
      observed = (pulseQueue.size() > 0) ? int'(pulseQueue[0]) : -1;
      checkOutput("simul_dq", observed, 2);

      // Return the line to idle with a complete dibit (bits 0,0)
      applyStimulus(0, 1);
      applyStimulus(0, 0);
      repeat (5) @(negedge rxClk);
      checkOutput("idle_return_dq", dq, 0);

      // Mid-dibit reset: a lone 0 bit is discarded, then bits 1,1 form one dibit
      pulseQueue.delete();
      applyStimulus(0, 1);
      repeat (3) @(negedge rxClk);
      rxReset = 1'b1;
      d = 1'b0;
      s = 1'b0;
      #40;
      rxReset = 1'b0;
      repeat (3) @(negedge rxClk);
      checkOutput("mid_reset_dq", dq, 0);
      applyStimulus(1, 0);
      applyStimulus(1, 1);
      repeat (5) @(negedge rxClk);
      checkOutput("mid_count", pulseQueue.size(), 1);
      observed = (pulseQueue.size() > 0) ? int'(pulseQueue[0]) : -1;
      checkOutput("mid_dq", observed, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
